// File: rtl/op_imm_encoder.sv
// RV32I OP-IMM instruction encoder with valid/ready output stream.
// Load-immediate requests expand to a single ADDI or to a LUI/ADDI pair.
//
// state   | meaning
// IDLE    | accepting requests; output register holds the latest word (or is empty)
// EMIT_LO | LUI is on the output, the follow-up ADDI waits in lo_q

`ifndef INST_ID_LEN
`define INST_ID_LEN 4
`define ADDI_ID  4'd1
`define SLTI_ID  4'd2
`define SLTIU_ID 4'd3
`define XORI_ID  4'd4
`define ORI_ID   4'd5
`define ANDI_ID  4'd6
`define SLLI_ID  4'd7
`define SRLI_ID  4'd8
`define SRAI_ID  4'd9
`endif

module op_imm_encoder (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_li,
    input  logic [`INST_ID_LEN-1:0] in_id,
    input  logic [4:0]              in_rd,
    input  logic [4:0]              in_rs1,
    input  logic [31:0]             in_imm,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_inst,
    output logic                    out_err,
    output logic                    out_last,
    output logic [15:0]             out_count
);

    localparam logic [6:0]  OPC_IMM = 7'b0010011;
    localparam logic [6:0]  OPC_LUI = 7'b0110111;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic [0:0] {S_IDLE, S_EMIT_LO} state_t;

    state_t      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic        out_err_q, out_err_d;
    logic        out_last_q, out_last_d;
    logic [15:0] out_count_q, out_count_d;
    logic [31:0] lo_q, lo_d;

    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        is_shift, id_known;
    logic        imm_fits, shamt_ok;
    logic [19:0] li_hi;
    logic [31:0] enc_inst, enc_lo;
    logic        enc_err, enc_last, enc_two;
    logic        accept, hs;

    assign imm_fits = (in_imm[31:11] == {21{in_imm[11]}});
    assign shamt_ok = (in_imm[31:5] == 27'd0);
    // (imm + 0x800) >> 12 reduces to the upper bits plus a carry out of bit 11
    assign li_hi    = in_imm[31:12] + {19'd0, in_imm[11]};

    always_comb begin
        f3       = 3'b000;
        f7       = 7'b0000000;
        is_shift = 1'b0;
        id_known = 1'b1;
        case (in_id)
            `ADDI_ID:  f3 = 3'b000;
            `SLTI_ID:  f3 = 3'b010;
            `SLTIU_ID: f3 = 3'b011;
            `XORI_ID:  f3 = 3'b100;
            `ORI_ID:   f3 = 3'b110;
            `ANDI_ID:  f3 = 3'b111;
            `SLLI_ID:  begin f3 = 3'b001; is_shift = 1'b1; end
            `SRLI_ID:  begin f3 = 3'b101; is_shift = 1'b1; end
            `SRAI_ID:  begin f3 = 3'b101; is_shift = 1'b1; f7 = 7'b0100000; end
            default:   id_known = 1'b0;
        endcase
    end

    always_comb begin
        enc_inst = NOP;
        enc_err  = 1'b0;
        enc_last = 1'b1;
        enc_two  = 1'b0;
        enc_lo   = {in_imm[11:0], in_rd, 3'b000, in_rd, OPC_IMM};
        if (in_li) begin
            if (imm_fits) begin
                enc_inst = {in_imm[11:0], 5'd0, 3'b000, in_rd, OPC_IMM};
            end else begin
                enc_inst = {li_hi, in_rd, OPC_LUI};
                if (in_imm[11:0] != 12'd0) begin
                    enc_two  = 1'b1;
                    enc_last = 1'b0;
                end
            end
        end else if (!id_known) begin
            enc_err = 1'b1;
        end else if (is_shift) begin
            if (shamt_ok) enc_inst = {f7, in_imm[4:0], in_rs1, f3, in_rd, OPC_IMM};
            else          enc_err  = 1'b1;
        end else begin
            if (imm_fits) enc_inst = {in_imm[11:0], in_rs1, f3, in_rd, OPC_IMM};
            else          enc_err  = 1'b1;
        end
    end

    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign hs       = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_err_d   = out_err_q;
        out_last_d  = out_last_q;
        lo_d        = lo_q;
        out_count_d = hs ? out_count_q + 16'd1 : out_count_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_inst_d  = enc_inst;
                    out_err_d   = enc_err;
                    out_last_d  = enc_last;
                    if (enc_two) begin
                        state_d = S_EMIT_LO;
                        lo_d    = enc_lo;
                    end
                end else if (hs) begin
                    out_valid_d = 1'b0;
                end
            end
            S_EMIT_LO: begin
                if (hs) begin
                    out_inst_d = lo_q;
                    out_err_d  = 1'b0;
                    out_last_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_inst_q  <= 32'd0;
            out_err_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_count_q <= 16'd0;
            lo_q        <= 32'd0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_err_q   <= out_err_d;
            out_last_q  <= out_last_d;
            out_count_q <= out_count_d;
            lo_q        <= lo_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_err   = out_err_q;
    assign out_last  = out_last_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_op_imm_encoder.sv
// Directed bench for op_imm_encoder: behavioural model feeds an expected-word
// queue checked on every handshake, plus literal expectations pinning the model.

`ifndef INST_ID_LEN
`define INST_ID_LEN 4
`define ADDI_ID  4'd1
`define SLTI_ID  4'd2
`define SLTIU_ID 4'd3
`define XORI_ID  4'd4
`define ORI_ID   4'd5
`define ANDI_ID  4'd6
`define SLLI_ID  4'd7
`define SRLI_ID  4'd8
`define SRAI_ID  4'd9
`endif

module tb_op_imm_encoder;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid, in_ready, in_li;
    logic [`INST_ID_LEN-1:0] in_id;
    logic [4:0]              in_rd, in_rs1;
    logic [31:0]             in_imm;
    logic                    out_valid, out_ready;
    logic [31:0]             out_inst;
    logic                    out_err, out_last;
    logic [15:0]             out_count;

    op_imm_encoder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_li(in_li), .in_id(in_id),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_err(out_err), .out_last(out_last), .out_count(out_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
        logic        last;
    } word_t;

    typedef struct {
        logic                    li;
        logic [`INST_ID_LEN-1:0] id;
        logic [4:0]              rd;
        logic [4:0]              rs1;
        logic [31:0]             imm;
        logic [31:0]             exp_inst;
        logic                    exp_err;
        int                      exp_n;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    word_t       expq[$];
    logic [15:0] model_count = 16'd0;
    int          cyc = 0;
    int          last_acc_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Spec-level model: field arithmetic from the ISA rules.
    function automatic void model(input logic li, input logic [`INST_ID_LEN-1:0] id,
                                  input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [31:0] imm,
                                  output int n, output word_t w0, output word_t w1);
        longint      simm;
        logic [31:0] rdw, rsw, f3, f7, hi, lo;
        bit          shift, known;
        simm  = longint'($signed(imm));
        rdw   = 32'(rd);
        rsw   = 32'(rs1);
        n     = 1;
        w0    = '{inst: 32'h13, err: 1'b0, last: 1'b1};
        w1    = '{inst: 32'h0, err: 1'b0, last: 1'b1};
        if (li) begin
            if (simm >= -2048 && simm <= 2047) begin
                w0.inst = ((imm & 32'hFFF) << 20) | (rdw << 7) | 32'h13;
            end else begin
                hi = (imm + 32'h800) >> 12;
                lo = imm & 32'hFFF;
                w0.inst = (hi << 12) | (rdw << 7) | 32'h37;
                if (lo != 0) begin
                    n       = 2;
                    w0.last = 1'b0;
                    w1.inst = (lo << 20) | (rdw << 15) | (rdw << 7) | 32'h13;
                end
            end
            return;
        end
        known = 1; shift = 0; f3 = 0; f7 = 0;
        case (id)
            `ADDI_ID:  f3 = 0;
            `SLTI_ID:  f3 = 2;
            `SLTIU_ID: f3 = 3;
            `XORI_ID:  f3 = 4;
            `ORI_ID:   f3 = 6;
            `ANDI_ID:  f3 = 7;
            `SLLI_ID:  begin f3 = 1; shift = 1; end
            `SRLI_ID:  begin f3 = 5; shift = 1; end
            `SRAI_ID:  begin f3 = 5; shift = 1; f7 = 32; end
            default:   known = 0;
        endcase
        if (!known || (shift && imm >= 32) || (!shift && (simm < -2048 || simm > 2047)))
            w0.err = 1'b1;
        else if (shift)
            w0.inst = (f7 << 25) | (imm << 20) | (rsw << 15) | (f3 << 12) | (rdw << 7) | 32'h13;
        else
            w0.inst = ((imm & 32'hFFF) << 20) | (rsw << 15) | (f3 << 12) | (rdw << 7) | 32'h13;
    endfunction

    task automatic send(input logic li, input logic [`INST_ID_LEN-1:0] id,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
        int    n, guard;
        bit    acc;
        word_t w0, w1;
        in_valid = 1'b1; in_li = li; in_id = id; in_rd = rd; in_rs1 = rs1; in_imm = imm;
        acc = 0; guard = 0;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            guard++;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=no_accept expected=accept");
        end else begin
            last_acc_cyc = cyc;
            model(li, id, rd, rs1, imm, n, w0, w1);
            expq.push_back(w0);
            if (n == 2) expq.push_back(w1);
        end
        #1;
        in_valid = 1'b0;
        if (acc) chk("latency_valid", 32'(out_valid), 32'd1);
    endtask

    logic [31:0] prev_inst;
    logic        prev_err, prev_last, prev_stall = 1'b0;

    always @(negedge clk) begin
        word_t e;
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            chk("out_count", 32'(out_count), 32'(model_count));
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_inst", out_inst, prev_inst);
                chk("hold_flags", {30'd0, out_err, out_last}, {30'd0, prev_err, prev_last});
                chk("hold_in_ready", 32'(in_ready), 32'd0);
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word actual=%h expected=none", out_inst);
                end else begin
                    e = expq.pop_front();
                    chk("word_inst", out_inst, e.inst);
                    chk("word_err", 32'(out_err), 32'(e.err));
                    chk("word_last", 32'(out_last), 32'(e.last));
                end
                model_count = model_count + 16'd1;
            end
            prev_stall = out_valid && !out_ready;
            prev_inst  = out_inst;
            prev_err   = out_err;
            prev_last  = out_last;
        end
    end

    vec_t vecs[16];

    initial begin
        int          n, first_cyc;
        word_t       w0, w1;
        logic [15:0] c0;

        vecs = '{
            '{1'b0, `ADDI_ID,  5'd5,  5'd6,  32'hFFFF_FFFF, 32'hFFF30293, 1'b0, 1},
            '{1'b0, `SRAI_ID,  5'd1,  5'd2,  32'd3,         32'h40315093, 1'b0, 1},
            '{1'b0, `SLLI_ID,  5'd1,  5'd2,  32'd32,        32'h00000013, 1'b1, 1},
            '{1'b0, `ADDI_ID,  5'd1,  5'd2,  32'd2048,      32'h00000013, 1'b1, 1},
            '{1'b0, `XORI_ID,  5'd7,  5'd8,  32'h7FF,       32'h7FF44393, 1'b0, 1},
            '{1'b0, `SLTI_ID,  5'd1,  5'd1,  32'hFFFF_F800, 32'h8000A093, 1'b0, 1},
            '{1'b0, `SLTIU_ID, 5'd2,  5'd3,  32'hFFFF_F7FF, 32'h00000013, 1'b1, 1},
            '{1'b0, `ORI_ID,   5'd4,  5'd4,  32'h10,        32'h01026213, 1'b0, 1},
            '{1'b0, `ANDI_ID,  5'd31, 5'd31, 32'hFF,        32'h0FFFFF93, 1'b0, 1},
            '{1'b0, `SRLI_ID,  5'd9,  5'd10, 32'd31,        32'h01F55493, 1'b0, 1},
            '{1'b0, 4'd0,      5'd3,  5'd3,  32'd1,         32'h00000013, 1'b1, 1},
            '{1'b1, 4'd15,     5'd10, 5'd9,  32'h1234_5FFF, 32'h12346537, 1'b0, 2},
            '{1'b1, 4'd0,      5'd10, 5'd0,  32'h0000_1000, 32'h00001537, 1'b0, 1},
            '{1'b1, 4'd0,      5'd3,  5'd0,  32'd5,         32'h00500193, 1'b0, 1},
            '{1'b1, 4'd0,      5'd2,  5'd0,  32'h800,       32'h00001137, 1'b0, 2},
            '{1'b1, 4'd0,      5'd6,  5'd0,  32'h8000_0000, 32'h80000337, 1'b0, 1}
        };

        rst = 1'b1; in_valid = 1'b0; in_li = 1'b0; in_id = '0;
        in_rd = '0; in_rs1 = '0; in_imm = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_inst", out_inst, 32'd0);
        chk("rst_err_last", {30'd0, out_err, out_last}, 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // literal pins on the model, including the second LI word
        model(1'b1, 4'd0, 5'd10, 5'd0, 32'h1234_5FFF, n, w0, w1);
        chk("pin_li_lo", w1.inst, 32'hFFF50513);
        chk("pin_li_last", {30'd0, w0.last, w1.last}, 32'd1);
        model(1'b1, 4'd0, 5'd2, 5'd0, 32'h800, n, w0, w1);
        chk("pin_li_lo2", w1.inst, 32'h80010113);

        foreach (vecs[i]) begin
            model(vecs[i].li, vecs[i].id, vecs[i].rd, vecs[i].rs1, vecs[i].imm, n, w0, w1);
            chk($sformatf("pin_inst_%0d", i), w0.inst, vecs[i].exp_inst);
            chk($sformatf("pin_err_%0d", i), 32'(w0.err), 32'(vecs[i].exp_err));
            chk($sformatf("pin_n_%0d", i), n, vecs[i].exp_n);
            send(vecs[i].li, vecs[i].id, vecs[i].rd, vecs[i].rs1, vecs[i].imm);
            chk($sformatf("dut_first_%0d", i), out_inst, vecs[i].exp_inst);
        end
        repeat (3) @(posedge clk);

        // backpressure across a two-word LI
        #1 out_ready = 1'b0;
        c0 = model_count;
        send(1'b1, 4'd0, 5'd10, 5'd0, 32'h1234_5FFF);
        repeat (3) begin
            @(negedge clk);
            chk("bp_lui", out_inst, 32'h12346537);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 chk("bp_addi", out_inst, 32'hFFF50513);
        chk("bp_addi_last", 32'(out_last), 32'd1);
        @(posedge clk);
        #1 chk("bp_drained", 32'(out_valid), 32'd0);
        chk("bp_count", 32'(out_count), 32'(c0 + 16'd2));

        // back-to-back stream
        c0 = model_count;
        send(1'b0, `ADDI_ID, 5'd1, 5'd0, 32'd1);
        first_cyc = last_acc_cyc;
        for (int k = 2; k <= 5; k++) send(1'b0, `ADDI_ID, 5'(k), 5'd0, 32'(k));
        chk("stream_span", 32'(last_acc_cyc - first_cyc), 32'd4);
        repeat (2) @(posedge clk);
        #1 chk("stream_count", 32'(out_count), 32'(c0 + 16'd5));
        chk("stream_drained", 32'(expq.size()), 32'd0);

        // reset while the ADDI half of an LI is pending
        out_ready = 1'b0;
        send(1'b1, 4'd0, 5'd10, 5'd0, 32'h1234_5FFF);
        @(posedge clk);
        #1 rst = 1'b1;
        expq.delete();
        model_count = 16'd0;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_count", 32'(out_count), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("mid_rst_no_addi", 32'(out_valid), 32'd0);
        chk("final_queue", 32'(expq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
